// File: rtl/fetch_sequencer.sv
// Program-flow controller: owns the PC, runs start/halt handshaking and steps
// through the two-word BNE form (opcode word followed by an absolute target word).
module fetch_sequencer #(
  parameter int          ADDR_W     = 9,
  parameter int unsigned START_ADDR = 0,
  parameter int          CNT_W      = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [8:0]        instruction,
  input  logic              branch_taken,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] pc,
  output logic              read_jump,
  output logic              run_en,
  output logic              done,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic [1:0] {IDLE, RUN, JOPND, HALTED} state_t;

  localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                read_jump_q, run_en_q, done_q;
  logic [ADDR_W-1:0]   target;
  logic                is_bne;

  // The operand word is an absolute target; fit it to the PC width.
  if (ADDR_W <= 9) begin : g_trunc
    assign target = instruction[ADDR_W-1:0];
  end else begin : g_zext
    assign target = {{(ADDR_W-9){1'b0}}, instruction};
  end

  assign is_bne = (instruction[8:6] == 3'b111);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, HALTED: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = START_PC;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        if (halt_req) begin
          state_d = HALTED;
        end else if (is_bne && branch_taken) begin
          state_d = JOPND;
          pc_d    = pc_q + ADDR_W'(1);
        end else if (is_bne) begin
          pc_d    = pc_q + ADDR_W'(2);
        end else begin
          pc_d    = pc_q + ADDR_W'(1);
        end
      end
      JOPND: begin
        state_d = RUN;
        pc_d    = target;
      end
      default: begin
        state_d = IDLE;
        pc_d    = START_PC;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      pc_q        <= START_PC;
      cnt_q       <= '0;
      read_jump_q <= 1'b0;
      run_en_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      read_jump_q <= (state_d == JOPND);
      run_en_q    <= (state_d == RUN);
      done_q      <= (state_d == HALTED);
    end
  end

  assign pc          = pc_q;
  assign read_jump   = read_jump_q;
  assign run_en      = run_en_q;
  assign done        = done_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a behavioural ROM and halt decode
// feed the DUT; per-cycle expectations are queued at drive time and popped after the edge.
module tb_fetch_sequencer;

  localparam int ADDR_W = 9;
  localparam int CNT_W  = 4;

  localparam logic [8:0] ALU  = 9'h001;
  localparam logic [8:0] HALT = 9'h080;
  localparam logic [8:0] BNE  = 9'h1C0;

  logic              Clk = 1'b0;
  logic              Reset = 1'b0;
  logic              Start = 1'b0;
  logic [8:0]        instruction;
  logic              branch_taken = 1'b0;
  logic              halt_req;
  logic [ADDR_W-1:0] pc;
  logic              read_jump, run_en, done;
  logic [CNT_W-1:0]  instr_count;

  logic [8:0] rom [512];

  fetch_sequencer #(.ADDR_W(ADDR_W), .START_ADDR(0), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .instruction(instruction),
    .branch_taken(branch_taken), .halt_req(halt_req), .pc(pc),
    .read_jump(read_jump), .run_en(run_en), .done(done), .instr_count(instr_count)
  );

  assign instruction = rom[pc];
  assign halt_req    = (instruction[8:6] == 3'b010) && (instruction[2:0] == 3'b000);

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [8:0]       pc;
    logic             rj;
    logic             run;
    logic             dn;
    logic [CNT_W-1:0] cnt;
  } obs_t;

  typedef struct {
    bit   st;
    bit   bt;
    obs_t exp;
  } vec_t;

  vec_t vecs [$];
  obs_t sb   [$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic obs_t mk(int p, bit rj, bit run, bit dn, int c);
    obs_t o;
    o.pc = 9'(p); o.rj = rj; o.run = run; o.dn = dn; o.cnt = CNT_W'(c);
    return o;
  endfunction

  function automatic obs_t now_obs();
    obs_t o;
    o.pc = pc; o.rj = read_jump; o.run = run_en; o.dn = done; o.cnt = instr_count;
    return o;
  endfunction

  task automatic check(string name, obs_t exp);
    obs_t got = now_obs();
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got pc=%h rj=%b run=%b done=%b cnt=%0d, want pc=%h rj=%b run=%b done=%b cnt=%0d",
                  name, got.pc, got.rj, got.run, got.dn, got.cnt,
                  exp.pc, exp.rj, exp.run, exp.dn, exp.cnt);
  endtask

  task automatic step(string name, bit st, bit bt, obs_t exp);
    obs_t e;
    @(negedge Clk);
    Start = st;
    branch_taken = bt;
    sb.push_back(exp);
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    check(name, e);
  endtask

  task automatic add(bit st, bit bt, int p, bit rj, bit run, bit dn, int c);
    vec_t v;
    v.st = st; v.bt = bt; v.exp = mk(p, rj, run, dn, c);
    vecs.push_back(v);
  endtask

  task automatic run_vecs(string tag);
    foreach (vecs[i]) step($sformatf("%s[%0d]", tag, i), vecs[i].st, vecs[i].bt, vecs[i].exp);
    vecs.delete();
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 512; i++) rom[i] = ALU;
  endtask

  initial begin
    fill_rom();
    // Asynchronous reset before any clock edge
    #3 Reset = 1'b1;
    #1 check("reset_async", mk(0, 0, 0, 0, 0));
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    add(0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    run_vecs("idle_hold");

    // Straight-line program ending in a halt at address 5
    rom[5] = HALT;
    add(1, 0, 0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 1, 0, 1);
    add(0, 0, 2, 0, 1, 0, 2);
    add(0, 0, 3, 0, 1, 0, 3);
    add(0, 0, 4, 0, 1, 0, 4);
    add(0, 0, 5, 0, 1, 0, 5);
    add(0, 0, 5, 0, 0, 1, 6);
    add(0, 0, 5, 0, 0, 1, 6);
    run_vecs("straight");

    // Taken BNE at 3 -> operand at 4 -> 0x040; Start mid-run ignored
    fill_rom();
    rom[3] = BNE; rom[4] = 9'h040; rom[9'h040] = HALT;
    add(1, 0, 0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 1, 0, 1);
    add(1, 0, 2, 0, 1, 0, 2);
    add(0, 0, 3, 0, 1, 0, 3);
    add(0, 1, 4, 1, 0, 0, 4);
    add(0, 0, 9'h040, 0, 1, 0, 4);
    add(0, 0, 9'h040, 0, 0, 1, 5);
    // Restart from HALTED, same BNE not taken skips the operand word
    add(1, 0, 0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 1, 0, 1);
    add(0, 0, 2, 0, 1, 0, 2);
    add(0, 0, 3, 0, 1, 0, 3);
    add(0, 0, 5, 0, 1, 0, 4);
    add(0, 0, 6, 0, 1, 0, 5);
    run_vecs("bne");

    // Address wrap: BNE at 0x1FF takes its operand from 0x000
    @(negedge Clk);
    rom[6] = HALT;
    add(0, 0, 6, 0, 0, 1, 6);
    run_vecs("to_halt");
    fill_rom();
    rom[0] = 9'h010; rom[1] = BNE; rom[2] = 9'h1FF; rom[9'h1FF] = BNE; rom[9'h010] = HALT;
    add(1, 0, 0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 1, 0, 1);
    add(0, 1, 2, 1, 0, 0, 2);
    add(0, 0, 9'h1FF, 0, 1, 0, 2);
    add(0, 1, 0, 1, 0, 0, 3);
    add(0, 0, 9'h010, 0, 1, 0, 3);
    add(0, 0, 9'h010, 0, 0, 1, 4);
    add(1, 0, 0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 1, 0, 1);
    add(0, 1, 2, 1, 0, 0, 2);
    add(0, 0, 9'h1FF, 0, 1, 0, 2);
    add(0, 0, 9'h001, 0, 1, 0, 3);
    add(0, 1, 2, 1, 0, 0, 4);
    run_vecs("wrap");

    // Now in JOPND: reset must clear without a clock edge
    #1 Reset = 1'b1;
    #1 check("reset_in_jopnd", mk(0, 0, 0, 0, 0));
    @(negedge Clk);
    Reset = 1'b0;
    add(0, 0, 0, 0, 0, 0, 0);
    run_vecs("post_reset");

    // Retired-instruction counter saturates instead of wrapping
    fill_rom();
    step("sat_start", 1, 0, mk(0, 0, 1, 0, 0));
    for (int i = 1; i <= 18; i++)
      step($sformatf("sat[%0d]", i), 0, 0, mk(i, 0, 1, 0, (i > 15) ? 15 : i));

    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Program-flow controller for the 9-bit single-cycle core. It owns the program counter, handles start/halt handshaking with the testbench, and sequences the two-word branch form: BNE followed by an absolute-target operand word. It drives the control decoder's read_jump input and gates architectural writes so that only real instructions retire.

Parameters:
ADDR_W, 9, program counter / instruction ROM address width
START_ADDR, 0, PC value loaded on each Start
CNT_W, 16, retired-instruction counter width

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Start  in  1  single-cycle launch request
instruction  in  9  word currently fetched at pc (combinational ROM read)
branch_taken  in  1  datapath BNE compare result for the current instruction (operands not equal)
halt_req  in  1  Halt decode from the control decoder
pc  out  ADDR_W  instruction ROM address
read_jump  out  1  high while the current word is a jump-target operand; fed to the control decoder
run_en  out  1  qualifies register-file and data-memory write enables
done  out  1  program finished
instr_count  out  CNT_W  retired instructions since the last Start

Behaviour:
- Reset is asynchronous and active-high. All state registers reset asynchronously.
- Reset values: state=IDLE, pc=START_ADDR, read_jump=0, run_en=0, done=0, instr_count=0.
- States: IDLE, RUN, JOPND, HALTED. Encoding is free. Outputs are registered, or decoded from state only.
- IDLE:
  - Start=1 -> RUN next edge; pc=START_ADDR; instr_count=0.
  - Otherwise hold.
- RUN (run_en=1, read_jump=0). Evaluated on each edge, in priority order:
  1. halt_req=1 -> HALTED; pc holds; the halt word counts as retired.
  2. instruction[8:6]=3'b111 and branch_taken=1 -> JOPND; pc=pc+1.
  3. instruction[8:6]=3'b111 and branch_taken=0 -> stay in RUN; pc=pc+2 (operand word skipped).
  4. Otherwise pc=pc+1.
  - Each RUN cycle increments instr_count by 1.
- JOPND (read_jump=1, run_en=0):
  - Exactly one cycle, then back to RUN.
  - pc = instruction target: low ADDR_W bits if ADDR_W<9, zero-extended if ADDR_W>9.
  - Not counted as retired. halt_req is ignored.
- HALTED (done=1, run_en=0, pc frozen):
  - Start=1 -> RUN; pc=START_ADDR; instr_count=0; done drops on the same edge.
- Start is ignored in RUN and JOPND.
- pc arithmetic is modulo 2^ADDR_W. A BNE at the last address takes its operand from address 0. pc+2 wraps identically.
- instr_count saturates at all-ones and does not wrap.
- Reset mid-JOPND: read_jump clears immediately (asynchronously) and the state returns to IDLE.
- run_en is 0 in every state other than RUN, so no register or memory write occurs while idle, halted, or during an operand word.
- Latency:
  - Start to first fetch at START_ADDR: 1 cycle.
  - halt_req to done=1: 1 cycle.
  - Taken BNE: 2 cycles total (BNE cycle + operand cycle).

Test Plan:
1. Reset with Reset=1 mid-cycle, then release -> pc=0, done=0, read_jump=0, run_en=0 asynchronously; FSM stays IDLE with Start=0.
2. Start pulse, straight-line ROM of 5 ALU ops then halt word 9'b010_xxx_000 at address 5 -> pc steps 0..5 one per cycle; done=1 one cycle after the halt fetch; instr_count=6; pc holds 5.
3. BNE at address 3 with branch_taken=1, operand word 9'h040 at address 4 -> pc=4 with read_jump=1 and run_en=0 for exactly one cycle, then pc=0x040 in RUN; instr_count does not count the operand word.
4. BNE at address 3 with branch_taken=0 -> pc 3 -> 5; read_jump stays 0.
5. ADDR_W=9, BNE at 0x1FF taken, word at 0x000 = 9'h010 -> operand fetched at pc=0, then pc=0x010. Same BNE not taken -> pc=0x001.
6. Start while in RUN is ignored. Start in HALTED restarts at START_ADDR with instr_count=0. Reset asserted during JOPND -> IDLE, pc=START_ADDR, read_jump=0 with no clock edge.
